bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Latency: done pulses WIDTH edges after the accepting edge; back-to-back conversions take WIDTH+1 edges each.
// Backpressure: start is ignored while busy=1; bcd/ovf hold their last result until the next conversion completes.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - asynchronous active-high reset
//   start - conversion request, accepted only while idle
//   bin   - unsigned binary input, captured on the accepting edge
//   busy  - high while a conversion is in progress
//   done  - one-cycle pulse when bcd/ovf carry a new result
//   bcd   - packed BCD result, digit 0 (units) in bits [3:0]
//   ovf   - last converted value was >= 10^DIGITS
module bin2bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      sh_q, sh_d;
    logic [4*DIGITS-1:0]   scr_q, scr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_acc_q, ovf_acc_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    // One double-dabble step: adjust every digit >= 5 by +3, then shift
    // {scratch, shift register} left by one.  The bit leaving the top digit
    // is the decimal carry out of the top digit, i.e. the value crossed
    // 10^DIGITS, and is dropped from the scratch (keeping it modulo 10^DIGITS).
    logic [4*DIGITS-1:0]   scr_adj;
    logic [4*DIGITS-1:0]   scr_shift;
    logic [WIDTH-1:0]      sh_shift;
    logic                  carry_out;

    always_comb begin
        scr_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            scr_adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? (scr_q[4*i +: 4] + 4'd3)
                                                          : scr_q[4*i +: 4];
        end
    end

    assign {carry_out, scr_shift, sh_shift} = {scr_adj, sh_q, 1'b0};

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d      = bin;
                    scr_d     = '0;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scr_d     = scr_shift;
                sh_d      = sh_shift;
                ovf_acc_d = ovf_acc_q | carry_out;
                if (cnt_q == LAST_ITER) begin
                    // Counter stops at WIDTH-1; it never needs the value WIDTH.
                    bcd_d   = scr_shift;
                    ovf_d   = ovf_acc_q | carry_out;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: randomized and directed conversions against a decimal reference model.
// Latency: expects done 14 edges after the accepting edge.
// Backpressure: checks start is ignored while busy and during reset.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 14;
    localparam int DIGITS = 4;

    logic                clk;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                ovf;

    int checks;
    int errors;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of v mod 10^DIGITS, units digit lowest.
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] res;
        int r;
        res = '0;
        r   = v;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    function automatic logic ref_ovf(input int v);
        return (v >= 10 ** DIGITS);
    endfunction

    // Drives one conversion and reports what was observed; bin is scrambled
    // during the conversion, which must not affect the result.
    task automatic run_conv(input logic [WIDTH-1:0] b, output int lat,
                            output logic [4*DIGITS-1:0] r, output logic o,
                            output int chg, output int busy_bad, output logic done_after);
        logic [4*DIGITS-1:0] old;
        old      = bcd;
        lat      = -1;
        chg      = 0;
        busy_bad = 0;
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = WIDTH'($urandom);
        if (busy !== 1'b1) busy_bad++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (bcd !== old) chg++;
            if (busy !== 1'b1) busy_bad++;
            bin = WIDTH'($urandom);
        end
        r = bcd;
        o = ovf;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        bin   = 14'd1234;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b bcd=%h ovf=%b, required 0/0/0000/0",
                     busy, done, bcd, ovf);
        end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
    endtask

    task automatic conv_and_check(input string name, input logic [WIDTH-1:0] b);
        int lat, chg, bb;
        logic [4*DIGITS-1:0] r;
        logic o, da;
        run_conv(b, lat, r, o, chg, bb, da);
        checks++;
        if (lat !== WIDTH) begin
            errors++;
            $display("FAIL %s latency: bin=%0d got %0d edges, required %0d", name, b, lat, WIDTH);
        end
        checks++;
        if (r !== ref_bcd(int'(b)) || o !== ref_ovf(int'(b))) begin
            errors++;
            $display("FAIL %s result: bin=%0d bcd=%h ovf=%b, required bcd=%h ovf=%b",
                     name, b, r, o, ref_bcd(int'(b)), ref_ovf(int'(b)));
        end
        checks++;
        if (chg !== 0 || bb !== 0 || da !== 1'b0) begin
            errors++;
            $display("FAIL %s protocol: bcd_changes=%0d busy_drops=%0d done_after=%b, required 0/0/0",
                     name, chg, bb, da);
        end
    endtask

    task automatic test_zero;
        conv_and_check("zero", 14'd0);
    endtask

    task automatic test_values;
        conv_and_check("v1234", 14'd1234);
        conv_and_check("v9999", 14'd9999);
        conv_and_check("v16383", 14'd16383);
        conv_and_check("v10000", 14'd10000);
        for (int i = 0; i < 20; i++) begin
            conv_and_check("random", WIDTH'($urandom_range(0, 16383)));
        end
    endtask

    task automatic test_start_ignored;
        logic [4*DIGITS-1:0] old;
        int ndone, chg, lat;
        old   = bcd;
        ndone = 0;
        chg   = 0;
        lat   = -1;
        @(negedge clk);
        bin   = 14'd42;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) bin = 14'd77;
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = k;
                checks++;
                if (bcd !== 16'h0042 || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL start_ignored result: bcd=%h ovf=%b, required 0042 0", bcd, ovf);
                end
            end else if (lat < 0 && bcd !== old) begin
                chg++;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || lat !== WIDTH || chg !== 0) begin
            errors++;
            $display("FAIL start_ignored protocol: dones=%0d latency=%0d bcd_changes=%0d, required 1/%0d/0",
                     ndone, lat, chg, WIDTH);
        end
    endtask

    task automatic test_reset_mid;
        int nd, nb;
        int lat, chg, bb;
        logic [4*DIGITS-1:0] r;
        logic o, da;
        @(negedge clk);
        bin   = 14'd5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid immediate: busy=%b done=%b bcd=%h ovf=%b, required 0/0/0000/0",
                     busy, done, bcd, ovf);
        end
        start = 1'b1;
        bin   = 14'd999;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_blocked: busy=%b, required 0", busy);
        end
        rst   = 1'b0;
        start = 1'b0;
        nd = 0;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (busy !== 1'b0) nb++;
        end
        checks++;
        if (nd !== 0 || nb !== 0) begin
            errors++;
            $display("FAIL reset_mid aborted: dones=%0d busy_cycles=%0d, required 0/0", nd, nb);
        end
        run_conv(14'd321, lat, r, o, chg, bb, da);
        checks++;
        if (lat !== WIDTH || r !== 16'h0321 || o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid fresh: latency=%0d bcd=%h ovf=%b, required %0d 0321 0",
                     lat, r, o, WIDTH);
        end
    endtask

    task automatic test_back_to_back;
        int prev, ndone;
        prev  = -1;
        ndone = 0;
        @(negedge clk);
        bin   = 14'd8;
        start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== ~done) begin
                errors++;
                $display("FAIL b2b busy: cycle=%0d busy=%b done=%b, required busy=~done", c, busy, done);
            end
            if (done === 1'b1) begin
                checks++;
                if (bcd !== 16'h0008 || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b result: bcd=%h ovf=%b, required 0008 0", bcd, ovf);
                end
                if (prev >= 0) begin
                    checks++;
                    if (c - prev !== WIDTH + 1) begin
                        errors++;
                        $display("FAIL b2b period: got %0d, required %0d", c - prev, WIDTH + 1);
                    end
                end
                prev = c;
                ndone++;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 5) begin
            errors++;
            $display("FAIL b2b count: got %0d dones, required 5", ndone);
        end
        repeat (30) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bin    = '0;
        test_reset();
        test_zero();
        test_values();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
